alu_seq: RTL
============

Name: alu_seq

Overview:
Sequencer that owns the 16-bit shared ALU and drives its func/a/b inputs cycle by cycle.
- Runs single ALU operations as one-shot commands.
- Runs a multi-cycle unsigned 16x16->16 shift-add multiply built only from the ALU's ADD, SHL and SHR functions, with exact overflow detection.
- Sits between the instruction decode/control unit and the ALU, with a start/done handshake toward control.

Parameters:
W, 16, datapath width; must match the ALU width.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  command request; sampled only when ready=1
op  in  4  0xxx = single ALU op with func=op[2:0]; 1000 = MUL; 1001-1111 reserved
opa  in  W  operand A (multiplicand for MUL)
opb  in  W  operand B (multiplier for MUL)
ready  out  1  1 in IDLE or DONE; command accepted at edge where start&ready
done  out  1  one-cycle pulse; result and flags valid from this cycle on
err  out  1  set with done for a reserved op; cleared at next acceptance
result  out  W  registered result; held until the next done
res_z, res_n, res_c  out  1 each  registered flags of result; res_c = ALU carry (single op) or overflow (MUL)
alu_func  out  3  to ALU func; ADD=000 SUB=001 INC=010 SHL=011 SHR=100 AND=101 ORR=110 NOT=111
alu_a, alu_b  out  W  to ALU operands
alu_r  in  W  ALU result (combinational, same cycle)
alu_z, alu_n, alu_c  in  1 each  ALU flags (same cycle)

Behaviour:
- Reset: state=IDLE; result=0, res_z/res_n/res_c=0, done=0, err=0, ready=1, alu_func=000, alu_a=alu_b=0; internal acc/m/q/m_lost=0. Reset mid-command abandons it; no done is produced.
- ALU interface:
  - alu_* outputs are combinational from state and internal registers.
  - ALU outputs are captured at the end of the same cycle.
- States: IDLE, EXEC, ADD, SHL, SHR, DONE.
- Accept (IDLE or DONE, start=1):
  - op[3]=0: latch opa, opb, func into internal registers -> EXEC.
  - op=1000: acc=0, m=opa, q=opb, m_lost=0, then:
    - opb=0 -> DONE with result=0, z=1, n=0, c=0.
    - opb[0]=1 -> ADD.
    - otherwise -> SHL.
  - Reserved op -> DONE with err=1; result and flags unchanged.
- start with ready=0 is ignored; there is no queueing.
- EXEC: drive func/a/b; capture result=alu_r, res_z/n/c=alu_z/n/c -> DONE. Latency start->done = 2 cycles.
- ADD: alu_func=ADD, a=acc, b=m. acc<=alu_r; ovf|=alu_c|m_lost -> SHL.
- SHL: alu_func=SHL, a=m. m<=alu_r; m_lost|=alu_c -> SHR.
- SHR: alu_func=SHR, a=q. q<=alu_r; then:
  - alu_z=1 -> FIN.
  - else alu_r[0]=1 -> ADD.
  - else -> SHL.
- FIN (the SHR->DONE transition): result=acc (including any add in progress), res_z=(acc==0), res_n=acc[W-1], res_c=ovf.
- ovf is exactly 1 iff the true product >= 2^W. A lost multiplicand bit only counts when a later ADD uses it.
- MUL latency: 1 + sum over bit positions 0..msb(opb) of (3 if bit set, else 2) cycles to done.
- DONE: done=1 for exactly one cycle; ready=1, so back-to-back commands are accepted with no bubble. Otherwise -> IDLE.
- Idle ALU drive: alu_func=000, alu_a=alu_b=0.
- Arithmetic: all unsigned, modulo 2^W; the carry of SUB is the ALU's borrow bit, passed through unchanged.

Test Plan:
1. After reset: rst=1 for 2 cycles, then release -> ready=1, done=0, result=0x0000, all flags 0, alu_func=000.
2. Single op: op=0000, opa=0xFFFF, opb=0x0001 -> done at cycle 2, result=0x0000, res_z=1, res_c=1, res_n=0. Then op=0001, opa=0x0003, opb=0x0005 -> result=0xFFFE, res_n=1, res_c=1.
3. MUL: opa=5, opb=3 -> ALU sequence ADD, SHL, SHR, ADD, SHL, SHR; done at cycle 7; result=0x000F, res_c=0. Assert start again during busy -> ignored.
4. MUL overflow: opa=0x0100, opb=0x0100 -> done at cycle 20; result=0x0000, res_z=1, res_c=1. Also opa=0x8000, opb=0x0001 -> result=0x8000, res_n=1, res_c=0.
5. MUL with opb=0, opa=0x1234 -> done at cycle 1, result=0x0000, res_z=1, res_c=0. Then reserved op=1011 -> done next cycle, err=1, result unchanged.
6. Reset mid-MUL: rst=1 at cycle 4 of opa=7, opb=0xFFFF -> next cycle state IDLE, ready=1, result=0, no done pulse. A fresh MUL opa=7, opb=0xFFFF -> result=0xFFF9, res_c=1.

Source files
------------

// File: rtl/alu_seq.sv
// Sequencer in front of the shared W-bit ALU: one-shot ALU commands plus an
// unsigned shift-add multiply (ADD/SHL/SHR only) with exact overflow detection.
module alu_seq #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [W-1:0] opa,
  input  logic [W-1:0] opb,
  output logic         ready,
  output logic         done,
  output logic         err,
  output logic [W-1:0] result,
  output logic         res_z,
  output logic         res_n,
  output logic         res_c,
  output logic [2:0]   alu_func,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_r,
  input  logic         alu_z,
  input  logic         alu_n,
  input  logic         alu_c
);
  typedef enum logic [2:0] {
    ST_IDLE, ST_EXEC, ST_ADD, ST_SHL, ST_SHR, ST_DONE
  } state_t;

  localparam logic [2:0] F_ADD = 3'b000;
  localparam logic [2:0] F_SHL = 3'b011;
  localparam logic [2:0] F_SHR = 3'b100;

  state_t         state_q, state_d;
  logic [2:0]     func_q, func_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [W-1:0]   acc_q, acc_d, m_q, m_d, q_q, q_d;
  logic           m_lost_q, m_lost_d, ovf_q, ovf_d;
  logic [W-1:0]   result_q, result_d;
  logic           z_q, z_d, n_q, n_d, c_q, c_d, err_q, err_d;

  always_comb begin
    state_d  = state_q;
    func_d   = func_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    m_d      = m_q;
    q_d      = q_q;
    m_lost_d = m_lost_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    z_d      = z_q;
    n_d      = n_q;
    c_d      = c_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          err_d = 1'b0;
          if (!op[3]) begin
            func_d  = op[2:0];
            a_d     = opa;
            b_d     = opb;
            state_d = ST_EXEC;
          end else if (op[2:0] == 3'b000) begin
            acc_d    = '0;
            m_d      = opa;
            q_d      = opb;
            m_lost_d = 1'b0;
            ovf_d    = 1'b0;
            if (opb == '0) begin
              result_d = '0;
              z_d      = 1'b1;
              n_d      = 1'b0;
              c_d      = 1'b0;
              state_d  = ST_DONE;
            end else if (opb[0]) begin
              state_d = ST_ADD;
            end else begin
              state_d = ST_SHL;
            end
          end else begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_EXEC: begin
        result_d = alu_r;
        z_d      = alu_z;
        n_d      = alu_n;
        c_d      = alu_c;
        state_d  = ST_DONE;
      end
      ST_ADD: begin
        // A multiplicand bit shifted out earlier only matters once it is added.
        acc_d   = alu_r;
        ovf_d   = ovf_q | alu_c | m_lost_q;
        state_d = ST_SHL;
      end
      ST_SHL: begin
        m_d      = alu_r;
        m_lost_d = m_lost_q | alu_c;
        state_d  = ST_SHR;
      end
      ST_SHR: begin
        q_d = alu_r;
        if (alu_z) begin
          result_d = acc_q;
          z_d      = (acc_q == '0);
          n_d      = acc_q[W-1];
          c_d      = ovf_q;
          state_d  = ST_DONE;
        end else if (alu_r[0]) begin
          state_d = ST_ADD;
        end else begin
          state_d = ST_SHL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    alu_func = 3'b000;
    alu_a    = '0;
    alu_b    = '0;
    case (state_q)
      ST_EXEC: begin
        alu_func = func_q;
        alu_a    = a_q;
        alu_b    = b_q;
      end
      ST_ADD: begin
        alu_func = F_ADD;
        alu_a    = acc_q;
        alu_b    = m_q;
      end
      ST_SHL: begin
        alu_func = F_SHL;
        alu_a    = m_q;
      end
      ST_SHR: begin
        alu_func = F_SHR;
        alu_a    = q_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      func_q   <= 3'b000;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      m_q      <= '0;
      q_q      <= '0;
      m_lost_q <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      c_q      <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      func_q   <= func_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      m_q      <= m_d;
      q_q      <= q_d;
      m_lost_q <= m_lost_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
      z_q      <= z_d;
      n_q      <= n_d;
      c_q      <= c_d;
      err_q    <= err_d;
    end
  end

  assign ready  = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign done   = (state_q == ST_DONE);
  assign err    = err_q;
  assign result = result_q;
  assign res_z  = z_q;
  assign res_n  = n_q;
  assign res_c  = c_q;
endmodule
